dsp_frame_accum: RTL and testbench
==================================

// Module: dsp_frame_accum
// PURPOSE
//  Consumer stage directly downstream of the DSP multiply-add block. Takes the 48-bit
//  P result stream (one product per clock, no stall) and sums FRAME_LEN consecutive
//  valid samples into one wide signed result, with optional saturation. Completed
//  frame sums are queued in a 2-entry result FIFO and drained over a valid/ready port.
// PARAMETERS
//  ACC_W      56  accumulator/result width in bits, signed; must be >= 49
//  FRAME_LEN  8   samples per frame, 2..256
//  SATURATE   1   1 = clamp to signed ACC_W min/max on overflow; 0 = two's-complement wrap
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst_n      in   1      asynchronous active-low reset
//  p_in       in   48     DSP P result, interpreted as signed two's complement
//  p_valid    in   1      p_in carries a sample this cycle; cannot be back-pressured
//  clr        in   1      sync clear: discard partial frame, clear drop_err
//  res_data   out  ACC_W  head-of-FIFO frame sum
//  res_sat    out  1      head result was saturated (SATURATE=1) or wrapped (SATURATE=0)
//  res_valid  out  1      FIFO not empty
//  res_ready  in   1      consumer accepts head result when res_valid & res_ready
//  busy       out  1      partial frame in progress (state ACCUM)
//  drop_err   out  1      sticky: a completed frame was lost because FIFO was full
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, acc=0, count=0, sat flag=0, FIFO empty;
//    res_data=0, res_sat=0, res_valid=0, busy=0, drop_err=0. Partial frame discarded.
//  - p_in sign-extended to ACC_W+1 bits; sum = acc + sext(p_in) computed at ACC_W+1.
//    Overflow when sum[ACC_W] != sum[ACC_W-1]. SATURATE=1: result clamps to
//    +2^(ACC_W-1)-1 or -2^(ACC_W-1) by sum sign, sat flag set; once saturated, frame
//    keeps accumulating from clamped value. SATURATE=0: keep low ACC_W bits, flag set.
//  - States: IDLE (count=0, acc=0) -> ACCUM on p_valid (acc=sext(p_in), count=1).
//    ACCUM: each p_valid adds p_in, count++. p_valid with count==FRAME_LEN-1 is the
//    final sample: push {sum, sat} to FIFO, acc=0, count=0, sat=0, return to IDLE.
//    Gaps (p_valid=0) hold state in any state; no timeout.
//  - Latency: final sample at posedge t -> res_valid=1 with its sum after posedge t
//    (visible cycle t+1) if FIFO was empty; otherwise queued behind older result.
//  - FIFO: 2 entries, in-order. Pop on res_valid & res_ready. Push and pop in same
//    cycle while full: pop first, push succeeds, no drop. Push while full with no pop:
//    new result discarded, FIFO unchanged, drop_err set (sticky).
//  - res_data/res_sat held stable while res_valid & !res_ready.
//  - clr: acc=0, count=0, sat=0, state IDLE, drop_err=0; FIFO contents and output
//    port untouched. clr and p_valid same cycle: clr wins, sample ignored, and a
//    frame whose final sample coincides with clr is not pushed.
//  - busy = (state==ACCUM). FRAME_LEN=1 not supported.
// TESTING (ACC_W=56, FRAME_LEN=4, SATURATE=1 unless noted)
//  1 Reset: assert rst_n=0 mid-frame after 2 samples -> all outputs 0 immediately;
//    after release, 4 samples of 1 -> res_data=4 (not 6).
//  2 Signed sum: p_in=10,-3,0xFFFF_FFFF_FFFF(-1),5 back-to-back -> res_data=11,
//    res_sat=0, res_valid one cycle after 4th sample; gaps of 3 idle cycles between
//    samples give the same result.
//  3 Saturation: ACC_W=49, four samples of 0x7FFF_FFFF_FFFF -> res_data=2^48-1,
//    res_sat=1; SATURATE=0 same stimulus -> res_data=low 49 bits of 4*(2^47-1), res_sat=1.
//  4 Backpressure: res_ready=0, complete 3 frames of sums 4,8,12 -> FIFO holds 4,8;
//    drop_err=1; then res_ready=1 -> reads 4 then 8, res_valid drops.
//  5 Full push+pop: FIFO full, res_ready=1 in same cycle as final sample -> no drop,
//    order preserved, drop_err stays 0.
//  6 clr: 2 samples then clr with p_valid=1 -> busy=0, next 4 samples of 2 -> res_data=8;
//    clr while FIFO holds a result -> result still readable, drop_err cleared.

Source files
------------

// File: rtl/dsp_frame_accum.sv
// ----------------------------------------------------------------------------
// dsp_frame_accum
//
// Sits directly behind the DSP multiply-add block. Sums FRAME_LEN consecutive
// valid 48-bit signed P results into one ACC_W-bit signed frame sum, with
// optional saturation. Completed frame sums are queued in a 2-entry FIFO and
// drained over a valid/ready port.
//
// Parameters
//   ACC_W      accumulator/result width (signed), must be >= 49
//   FRAME_LEN  samples per frame, 2..256
//   SATURATE   1: clamp to signed ACC_W min/max on overflow; 0: wrap
//
// Ports
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   p_in       DSP P result, signed two's complement
//   p_valid    p_in carries a sample this cycle (no back-pressure)
//   clr        sync clear: drop partial frame, clear drop_err (FIFO kept)
//   res_data   head-of-FIFO frame sum
//   res_sat    head result saturated (SATURATE=1) or wrapped (SATURATE=0)
//   res_valid  FIFO not empty
//   res_ready  consumer accepts head when res_valid & res_ready
//   busy       partial frame in progress
//   drop_err   sticky: completed frame lost because FIFO was full
// ----------------------------------------------------------------------------
module dsp_frame_accum #(
    parameter int ACC_W     = 56,
    parameter int FRAME_LEN = 8,
    parameter bit SATURATE  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      p_in,
    input  logic             p_valid,
    input  logic             clr,
    output logic [ACC_W-1:0] res_data,
    output logic             res_sat,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             drop_err
);

    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // Frame accumulator state
    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;

    state_t            w_state_nxt;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_sat_nxt;
    logic              w_push;

    // Adder / overflow
    logic [ACC_W:0]    w_sum;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_sum_fix;

    // Result FIFO
    logic [ACC_W-1:0]  r_fifo_data [2];
    logic              r_fifo_sat  [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_fifo_cnt;
    logic              r_drop_err;

    logic              w_pop;
    logic              w_full;
    logic              w_wr_en;
    logic              w_drop;

    // One guard bit above ACC_W: overflow shows up as a disagreement between
    // the guard bit and the ACC_W sign bit.
    assign w_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-48){p_in[47]}}, p_in};
    assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_sum_fix = w_sum[ACC_W-1:0];
        if (w_ovf && SATURATE) begin
            w_sum_fix = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state / datapath. clr has priority over any sample, so a
    // final sample arriving with clr is never pushed.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        w_push      = 1'b0;

        if (clr) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_sat_nxt   = 1'b0;
        end else if (p_valid) begin
            case (r_state)
                S_IDLE: begin
                    // r_acc is zero here, so w_sum is just sext(p_in)
                    w_state_nxt = S_ACCUM;
                    w_acc_nxt   = w_sum_fix;
                    w_cnt_nxt   = CNT_W'(1);
                    w_sat_nxt   = w_ovf;
                end
                S_ACCUM: begin
                    if (r_cnt == LAST_CNT) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_sat_nxt   = 1'b0;
                    end else begin
                        w_acc_nxt = w_sum_fix;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        w_sat_nxt = r_sat | w_ovf;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO. A pop frees the slot before the push in the same cycle,
    // so a full FIFO only drops when nothing is being read.
    // ------------------------------------------------------------------
    assign w_pop   = (r_fifo_cnt != 2'd0) && res_ready;
    assign w_full  = (r_fifo_cnt == 2'd2);
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_sat[i]  <= 1'b0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_fifo_data[r_wr_ptr] <= w_sum_fix;
                r_fifo_sat[r_wr_ptr]  <= r_sat | w_ovf;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_err <= 1'b0;
        end else if (clr) begin
            r_drop_err <= 1'b0;
        end else if (w_drop) begin
            r_drop_err <= 1'b1;
        end
    end

    assign res_data  = r_fifo_data[r_rd_ptr];
    assign res_sat   = r_fifo_sat[r_rd_ptr];
    assign res_valid = (r_fifo_cnt != 2'd0);
    assign busy      = (r_state == S_ACCUM);
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_dsp_frame_accum.sv
// ----------------------------------------------------------------------------
// tb_dsp_frame_accum
//
// Directed bench for dsp_frame_accum. Main instance: ACC_W=56, FRAME_LEN=4,
// SATURATE=1. Two ACC_W=49 instances (SATURATE=1 and 0) cover overflow.
// Expected frame sums of the main instance go into a queue as frames are
// driven; a negedge monitor pops and compares on every accepted result.
// ----------------------------------------------------------------------------
module tb_dsp_frame_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] p_in;
    logic        p_valid;
    logic        clr;
    logic [55:0] res_data;
    logic        res_sat;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        drop_err;

    // Shared stimulus for the two 49-bit instances
    logic [47:0] p_in_s;
    logic        p_valid_s;
    logic        clr_s;
    logic        res_ready_s;
    logic [48:0] res_data_sat, res_data_wrap;
    logic        res_sat_sat, res_sat_wrap;
    logic        res_valid_sat, res_valid_wrap;
    logic        busy_sat, busy_wrap;
    logic        drop_err_sat, drop_err_wrap;

    int errors = 0;
    int checks = 0;

    logic [56:0] sb[$];   // {sat, data}

    always #5 clk = ~clk;

    dsp_frame_accum #(.ACC_W(56), .FRAME_LEN(4), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .clr(clr),
        .res_data(res_data), .res_sat(res_sat), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .drop_err(drop_err)
    );

    dsp_frame_accum #(.ACC_W(49), .FRAME_LEN(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .p_in(p_in_s), .p_valid(p_valid_s), .clr(clr_s),
        .res_data(res_data_sat), .res_sat(res_sat_sat), .res_valid(res_valid_sat),
        .res_ready(res_ready_s), .busy(busy_sat), .drop_err(drop_err_sat)
    );

    dsp_frame_accum #(.ACC_W(49), .FRAME_LEN(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .p_in(p_in_s), .p_valid(p_valid_s), .clr(clr_s),
        .res_data(res_data_wrap), .res_sat(res_sat_wrap), .res_valid(res_valid_wrap),
        .res_ready(res_ready_s), .busy(busy_wrap), .drop_err(drop_err_wrap)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after posedge; the monitor samples at negedge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [47:0] v);
        p_in    = v;
        p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        p_in    = '0;
    endtask

    task automatic frame(input logic [47:0] v);
        for (int i = 0; i < 4; i++) send(v);
    endtask

    task automatic send_s(input logic [47:0] v);
        p_in_s    = v;
        p_valid_s = 1'b1;
        tick();
        p_valid_s = 1'b0;
    endtask

    task automatic sb_push(input logic [55:0] d, input logic s);
        sb.push_back({s, d});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: a handshake visible at negedge completes at the
    // following posedge, so compare the head here.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed=%0h expected=none", res_data);
            end
            if (sb.size() > 0) begin
                logic [56:0] e;
                e = sb.pop_front();
                chk("sb_data", 64'(res_data), 64'(e[55:0]));
                chk("sb_sat", 64'(res_sat), 64'(e[56]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; p_in = '0; p_valid = 1'b0; clr = 1'b0; res_ready = 1'b0;
        p_in_s = '0; p_valid_s = 1'b0; clr_s = 1'b0; res_ready_s = 1'b0;
        idle(3);
        rst_n = 1'b1;
        tick();

        // ---- 1: reset mid-frame, with a result sitting in the FIFO ----
        chk("rst_idle_valid", 64'(res_valid), 64'd0);
        chk("rst_idle_busy", 64'(busy), 64'd0);
        frame(48'd1);                       // held (ready=0), lost by reset
        send(48'd1);
        send(48'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_valid", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_sat", 64'(res_sat), 64'd0);
        chk("rst_drop", 64'(drop_err), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        res_ready = 1'b1;
        sb_push(56'd4, 1'b0);
        frame(48'd1);
        chk("rst_frame_latency", 64'(res_valid), 64'd1);
        wait_drain("drain1");

        // ---- 2: signed sum, back-to-back then with gaps ----
        sb_push(56'd11, 1'b0);
        send(48'd10);
        send(-48'sd3);
        send(48'hFFFF_FFFF_FFFF);
        chk("b2b_pre_valid", 64'(res_valid), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);
        send(48'd5);
        chk("b2b_latency", 64'(res_valid), 64'd1);
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        wait_drain("drain2a");
        sb_push(56'd11, 1'b0);
        send(48'd10);        idle(3);
        send(-48'sd3);       idle(3);
        send(48'hFFFF_FFFF_FFFF); idle(3);
        chk("gap_hold_busy", 64'(busy), 64'd1);
        chk("gap_pre_valid", 64'(res_valid), 64'd0);
        send(48'd5);
        chk("gap_latency", 64'(res_valid), 64'd1);
        wait_drain("drain2b");

        // ---- 3: 49-bit overflow, saturate vs wrap ----
        for (int i = 0; i < 4; i++) send_s(48'h7FFF_FFFF_FFFF);
        chk("sat_valid", 64'(res_valid_sat), 64'd1);
        chk("sat_data", 64'(res_data_sat), 64'h0000_FFFF_FFFF_FFFF);
        chk("sat_flag", 64'(res_sat_sat), 64'd1);
        chk("sat_busy", 64'(busy_sat), 64'd0);
        chk("wrap_valid", 64'(res_valid_wrap), 64'd1);
        chk("wrap_data", 64'(res_data_wrap), 64'h0001_FFFF_FFFF_FFFC);
        chk("wrap_flag", 64'(res_sat_wrap), 64'd1);
        chk("wrap_busy", 64'(busy_wrap), 64'd0);
        chk("s_drop", 64'({drop_err_sat, drop_err_wrap}), 64'd0);

        // ---- 4: backpressure and drop ----
        res_ready = 1'b0;
        sb_push(56'd4, 1'b0);
        sb_push(56'd8, 1'b0);
        frame(48'd1);
        frame(48'd2);
        chk("bp_full_nodrop", 64'(drop_err), 64'd0);
        frame(48'd3);                       // FIFO full, no pop: lost
        chk("bp_drop", 64'(drop_err), 64'd1);
        chk("bp_hold_valid", 64'(res_valid), 64'd1);
        chk("bp_hold_data", 64'(res_data), 64'd4);
        idle(2);
        chk("bp_hold_data2", 64'(res_data), 64'd4);
        res_ready = 1'b1;
        wait_drain("drain4");
        tick();
        chk("bp_empty", 64'(res_valid), 64'd0);
        chk("bp_drop_sticky", 64'(drop_err), 64'd1);

        // ---- 5: push and pop together while full ----
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        res_ready = 1'b0;
        sb_push(56'd4, 1'b0);
        sb_push(56'd8, 1'b0);
        sb_push(56'd12, 1'b0);
        frame(48'd1);
        frame(48'd2);
        send(48'd3); send(48'd3); send(48'd3);
        res_ready = 1'b1;
        send(48'd3);
        chk("pp_nodrop", 64'(drop_err), 64'd0);
        wait_drain("drain5");
        chk("pp_nodrop_end", 64'(drop_err), 64'd0);

        // ---- 6: clr ----
        send(48'd1);
        send(48'd1);
        p_in = 48'd1; p_valid = 1'b1; clr = 1'b1;
        tick();
        p_valid = 1'b0; clr = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        sb_push(56'd8, 1'b0);
        frame(48'd2);
        wait_drain("drain6a");
        // final sample coinciding with clr is not pushed
        send(48'd1); send(48'd1); send(48'd1);
        p_in = 48'd1; p_valid = 1'b1; clr = 1'b1;
        tick();
        p_valid = 1'b0; clr = 1'b0;
        chk("clr_final_valid", 64'(res_valid), 64'd0);
        chk("clr_final_busy", 64'(busy), 64'd0);
        idle(2);
        chk("clr_final_valid2", 64'(res_valid), 64'd0);
        // clr keeps FIFO contents, clears drop_err
        res_ready = 1'b0;
        sb_push(56'd4, 1'b0);
        sb_push(56'd8, 1'b0);
        frame(48'd1);
        frame(48'd2);
        frame(48'd3);
        chk("clr_pre_drop", 64'(drop_err), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_drop", 64'(drop_err), 64'd0);
        chk("clr_keep_valid", 64'(res_valid), 64'd1);
        chk("clr_keep_data", 64'(res_data), 64'd4);
        res_ready = 1'b1;
        wait_drain("drain6b");
        tick();
        chk("end_empty", 64'(res_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
